// File: rtl/gearbox_pkg.sv
// gearbox_pkg: shared constants and state encoding for the 67b->64b TX
// gearbox sequencer.
//   GB_IN_W   input block width (64b/67b word)
//   GB_OUT_W  datapath output width per cycle
//   GB_CNT_W  width of fill level and sequence counters
//   GB_STEP   fill growth on a load cycle (IN_W - OUT_W)
package gearbox_pkg;

  localparam int GB_IN_W  = 67;
  localparam int GB_OUT_W = 64;
  localparam int GB_CNT_W = 7;
  localparam int GB_STEP  = GB_IN_W - GB_OUT_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gb_state_e;

endpackage

// File: rtl/gearbox_tx_ctrl_if.sv
// gearbox_tx_ctrl_if: handshake and datapath-control bundle of the TX
// gearbox sequencer.
//   ENABLE, DATA_VALID          : upstream/control -> sequencer
//   DATA_READY                  : word consumed this cycle
//   GB_LOAD, GB_IDLE_FILL,
//   GB_SHIFT, GB_OUT_VALID      : datapath controls
//   SEQ_CNT, SEQ_WRAP           : 67-cycle sequence position / wrap pulse
//   UNDERFLOW                   : sticky upstream underflow flag
// slave = sequencer side, master = upstream/datapath side.
interface gearbox_tx_ctrl_if #(
  parameter int CNT_W = gearbox_pkg::GB_CNT_W
);
  logic             ENABLE;
  logic             DATA_VALID;
  logic             DATA_READY;
  logic             GB_LOAD;
  logic             GB_IDLE_FILL;
  logic [CNT_W-1:0] GB_SHIFT;
  logic             GB_OUT_VALID;
  logic [CNT_W-1:0] SEQ_CNT;
  logic             SEQ_WRAP;
  logic             UNDERFLOW;

  modport slave (
    input  ENABLE, DATA_VALID,
    output DATA_READY, GB_LOAD, GB_IDLE_FILL, GB_SHIFT, GB_OUT_VALID,
           SEQ_CNT, SEQ_WRAP, UNDERFLOW
  );

  modport master (
    output ENABLE, DATA_VALID,
    input  DATA_READY, GB_LOAD, GB_IDLE_FILL, GB_SHIFT, GB_OUT_VALID,
           SEQ_CNT, SEQ_WRAP, UNDERFLOW
  );
endinterface

// File: rtl/gearbox_fill_tracker.sv
// gearbox_fill_tracker: bit-fill level f of the gearbox buffer plus the
// IN_W-long sequence counter.
//   USER_CLK  clock
//   RESET     synchronous active-high reset
//   step      advance one gearbox cycle; when low, f and seq flush to 0
//   fill      registered fill level f (barrel offset)
//   accept    f < OUT_W: a new input word is appended this cycle
//   seq       sequence position 0..IN_W-1
//   seq_wrap  seq is at IN_W-1
module gearbox_fill_tracker
  import gearbox_pkg::*;
#(
  parameter int IN_W  = GB_IN_W,
  parameter int OUT_W = GB_OUT_W,
  parameter int CNT_W = GB_CNT_W
) (
  input  logic             USER_CLK,
  input  logic             RESET,
  input  logic             step,
  output logic [CNT_W-1:0] fill,
  output logic             accept,
  output logic [CNT_W-1:0] seq,
  output logic             seq_wrap
);

  localparam logic [CNT_W-1:0] OUT_C  = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(IN_W - OUT_W);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(IN_W - 1);

  assign accept   = (fill < OUT_C);
  assign seq_wrap = (seq == LAST_C);

  // Since gcd(IN_W,OUT_W)=1, f returns to 0 exactly when seq wraps, so the
  // two registers stay aligned without cross-checking each other.
  always_ff @(posedge USER_CLK) begin
    if (RESET || !step) begin
      fill <= '0;
      seq  <= '0;
    end else begin
      fill <= accept ? fill + STEP_C : fill - OUT_C;
      seq  <= seq_wrap ? '0 : seq + 1'b1;
    end
  end

endmodule

// File: rtl/gearbox_tx_ctrl.sv
// gearbox_tx_ctrl: sequencer for the 67b->64b Interlaken TX gearbox.
//   USER_CLK  sole clock, rising edge
//   RESET     synchronous active-high reset
//   gb        gearbox_tx_ctrl_if.slave: ENABLE/DATA_VALID in; DATA_READY,
//             GB_LOAD, GB_IDLE_FILL, GB_SHIFT, GB_OUT_VALID, SEQ_CNT,
//             SEQ_WRAP, UNDERFLOW out
// IDLE holds everything at 0; RUN steps the fill tracker every cycle. A
// missing upstream word on a load cycle is replaced by idle fill and the
// sequence still advances so the framing period is preserved.
module gearbox_tx_ctrl
  import gearbox_pkg::*;
#(
  parameter int IN_W  = GB_IN_W,
  parameter int OUT_W = GB_OUT_W,
  parameter int CNT_W = GB_CNT_W
) (
  input  logic                USER_CLK,
  input  logic                RESET,
  gearbox_tx_ctrl_if.slave    gb
);

  gb_state_e        state_q, state_d;
  logic             run;
  logic             step;
  logic             accept;
  logic [CNT_W-1:0] fill;
  logic [CNT_W-1:0] seq;
  logic             seq_wrap;
  logic             out_vld_q;
  logic             uflow_q;
  logic             load;
  logic             idle_fill;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge USER_CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    run       = 1'b0;
    load      = 1'b0;
    idle_fill = 1'b0;
    case (state_q)
      IDLE: begin
        if (gb.ENABLE) state_d = RUN;
      end
      RUN: begin
        run       = 1'b1;
        load      = accept;
        // Same-cycle substitution: the datapath swaps in idle fill for the
        // very word slot that upstream failed to supply.
        idle_fill = accept & ~gb.DATA_VALID;
        if (!gb.ENABLE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tracker advances only while staying in RUN; any other case flushes it,
  // which also guarantees f=0/seq=0 on the first RUN cycle.
  assign step = run & gb.ENABLE;

  gearbox_fill_tracker #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_fill (
    .USER_CLK (USER_CLK),
    .RESET    (RESET),
    .step     (step),
    .fill     (fill),
    .accept   (accept),
    .seq      (seq),
    .seq_wrap (seq_wrap)
  );

  // Output becomes meaningful one cycle after the first load.
  always_ff @(posedge USER_CLK) begin
    if (RESET) out_vld_q <= 1'b0;
    else       out_vld_q <= step;
  end

  always_ff @(posedge USER_CLK) begin
    if (RESET)          uflow_q <= 1'b0;
    else if (idle_fill) uflow_q <= 1'b1;
  end

  assign gb.DATA_READY   = load;
  assign gb.GB_LOAD      = load;
  assign gb.GB_IDLE_FILL = idle_fill;
  assign gb.GB_SHIFT     = fill;
  assign gb.GB_OUT_VALID = out_vld_q;
  assign gb.SEQ_CNT      = seq;
  assign gb.SEQ_WRAP     = run & seq_wrap;
  assign gb.UNDERFLOW    = uflow_q;

endmodule
